// File: rtl/mem_bus_if.sv
// Load/store bus adapter: turns level-held read/write requests into word-aligned,
// single-outstanding bus beats, splitting misaligned accesses into two beats.
module mem_bus_if #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic [1:0]  byte_size,
    output logic [31:0] mem_data_in,
    output logic        mem_read_ready,
    output logic        mem_write_ready,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [63:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [63:0] b, input logic [1:0] off,
                                            input logic [1:0] sz);
        logic [63:0] sh;
        logic [31:0] keep;
        sh = b >> {off, 3'b000};
        case (sz)
            2'd1:    keep = 32'h0000_00FF;
            2'd2:    keep = 32'h0000_FFFF;
            default: keep = 32'hFFFF_FFFF;
        endcase
        return sh[31:0] & keep;
    endfunction

    logic [7:0]  mask8;
    logic [63:0] wdata64;
    logic        need_beat1;
    logic        in_req;
    logic        beat1_sel;
    logic [31:0] base_addr;

    // Lane placement is derived from the latched request so the bus side stays stable.
    assign mask8      = {4'b0000, size_mask(size_q)} << addr_q[1:0];
    assign wdata64    = {32'h0, data_q} << {addr_q[1:0], 3'b000};
    assign need_beat1 = |mask8[7:4];
    assign base_addr  = {addr_q[31:2], 2'b00};
    assign in_req     = (state_q == S_REQ0) || (state_q == S_REQ1);
    assign beat1_sel  = (state_q == S_REQ1);

    assign bus_req         = in_req;
    assign bus_we          = in_req & we_q;
    assign bus_addr        = !in_req ? 32'h0 : (beat1_sel ? base_addr + 32'd4 : base_addr);
    assign bus_wstrb       = !(in_req && we_q) ? 4'h0 : (beat1_sel ? mask8[7:4] : mask8[3:0]);
    assign bus_wdata       = !(in_req && we_q) ? 32'h0 :
                             (beat1_sel ? wdata64[63:32] : wdata64[31:0]);
    assign mem_read_ready  = (state_q == S_RESP) & ~we_q;
    assign mem_write_ready = (state_q == S_RESP) & we_q;
    assign mem_err         = (state_q == S_RESP) & err_q;
    assign mem_data_in     = rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        we_d    = we_q;
        err_d   = err_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_read_en || mem_write_en) begin
                    we_d = mem_write_en;
                    if ((mem_read_en && mem_write_en) || (byte_size == 2'd3)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                        if (!mem_write_en) begin
                            rdata_d = 32'h0;
                        end
                    end else begin
                        addr_d  = mem_addr;
                        data_d  = mem_data;
                        size_d  = byte_size;
                        err_d   = 1'b0;
                        cnt_d   = 8'd0;
                        state_d = S_REQ0;
                    end
                end
            end
            S_REQ0, S_REQ1: begin
                if (bus_gnt) begin
                    state_d = (state_q == S_REQ0) ? S_WAIT0 : S_WAIT1;
                    cnt_d   = 8'd0;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT0, S_WAIT1: begin
                if (bus_rvalid) begin
                    if (state_q == S_WAIT0) begin
                        buf_d[31:0] = bus_rdata;
                    end else begin
                        buf_d[63:32] = bus_rdata;
                    end
                    err_d = err_q | bus_err;
                    cnt_d = 8'd0;
                    if ((state_q == S_WAIT0) && need_beat1 && !err_d) begin
                        state_d = S_REQ1;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Read result is registered on the way into RESP so it is valid during the pulse.
        if ((state_d == S_RESP) && (state_q != S_RESP) && (state_q != S_IDLE) && !we_q) begin
            rdata_d = err_d ? 32'h0 : extract(buf_d, addr_q[1:0], size_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            size_q  <= 2'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            buf_q   <= 64'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            we_q    <= we_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: memory-backed bus slave plus a byte-level reference memory.
module tb_mem_bus_if;

    logic        clk, rst;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_addr, mem_data;
    logic [1:0]  byte_size;
    logic [31:0] mem_data_in;
    logic        mem_read_ready, mem_write_ready, mem_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    mem_bus_if #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_data(mem_data), .byte_size(byte_size),
        .mem_data_in(mem_data_in), .mem_read_ready(mem_read_ready),
        .mem_write_ready(mem_write_ready), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } beat_t;

    beat_t       beats[$];
    logic [31:0] rd_force[$];
    logic [31:0] smem[logic [31:0]];
    logic [7:0]  mmem[logic [31:0]];
    int          gnt_wait, rv_wait;
    bit          gnt_block, inject_rv, err_next;
    int          checks, errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
    endfunction

    function automatic logic [7:0] model_byte(input logic [31:0] a);
        logic [31:0] w;
        if (mmem.exists(a)) return mmem[a];
        w = init_word({a[31:2], 2'b00});
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < n; i++) r = r | (32'(model_byte(a + 32'(i))) << (8 * i));
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) mmem[a + 32'(i)] = d[8*i +: 8];
    endtask

    // Word-granular bus slave with programmable grant/response latency.
    initial begin : slave
        int          wcnt, rcnt;
        bit          pend;
        beat_t       cur;
        logic [31:0] w;
        wcnt = 0; rcnt = 0; pend = 0; cur = '0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
        forever begin
            @(negedge clk);
            bus_gnt = 0; bus_rvalid = 0; bus_err = 0;
            if (inject_rv) begin
                bus_rvalid = 1; bus_rdata = 32'hCAFE_F00D;
            end else if (pend) begin
                if (rcnt >= rv_wait) begin
                    bus_rvalid = 1; pend = 0;
                    if (err_next) begin
                        bus_err = 1; bus_rdata = 32'h0;
                    end else if (cur.we) begin
                        w = smem.exists(cur.addr) ? smem[cur.addr] : init_word(cur.addr);
                        for (int l = 0; l < 4; l++) if (cur.strb[l]) w[8*l +: 8] = cur.wdata[8*l +: 8];
                        smem[cur.addr] = w;
                    end else if (rd_force.size() > 0) begin
                        bus_rdata = rd_force.pop_front();
                    end else begin
                        bus_rdata = smem.exists(cur.addr) ? smem[cur.addr] : init_word(cur.addr);
                    end
                end else rcnt++;
            end else if (bus_req && !gnt_block && !rst) begin
                if (wcnt >= gnt_wait) begin
                    bus_gnt = 1;
                    cur.addr = bus_addr; cur.we = bus_we; cur.strb = bus_wstrb; cur.wdata = bus_wdata;
                    beats.push_back(cur);
                    pend = 1; rcnt = 0; wcnt = 0;
                end else wcnt++;
            end
        end
    end

    task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, output logic [31:0] rdata, output bit er,
                             output bit rr, output bit wr, output int lat, output int nreq);
        beats.delete();
        rdata = 32'h0; er = 0; rr = 0; wr = 0; lat = -1; nreq = 0;
        @(posedge clk); #1;
        mem_addr = a; mem_data = d; byte_size = sz;
        mem_read_en = !we; mem_write_en = we;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus_req) nreq++;
            if (mem_read_ready || mem_write_ready) begin
                lat = c; rdata = mem_data_in; er = mem_err; rr = mem_read_ready; wr = mem_write_ready;
                break;
            end
        end
        @(posedge clk); #1;
        mem_read_en = 0; mem_write_en = 0;
        @(negedge clk);
        if (lat < 0) check_eq("ready_seen", 0, 1);
        check_eq("ready_one_cycle", {mem_read_ready, mem_write_ready}, 2'b00);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd, exp, a, d;
        bit          er, rr, wr, we;
        int          lat, nreq, cnt, n, expb;
        logic [1:0]  sz;
        checks = 0; errors = 0;
        gnt_wait = 0; rv_wait = 0; gnt_block = 0; inject_rv = 0; err_next = 0;
        rst = 1; mem_read_en = 0; mem_write_en = 0; mem_addr = 0; mem_data = 0; byte_size = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_bus", {bus_req, bus_we, bus_wstrb, bus_addr}, 0);
        check_eq("reset_wdata", bus_wdata, 0);
        check_eq("reset_mem", {mem_read_ready, mem_write_ready, mem_err, mem_data_in}, 0);
        rst = 0;

        rd_force.push_back(32'hDEAD_BEEF);
        do_access(0, 32'h100, 0, 2'd0, rd, er, rr, wr, lat, nreq);
        check_eq("lw_lat", lat, 3);
        check_eq("lw_data", rd, 32'hDEAD_BEEF);
        check_eq("lw_rdy", {rr, wr, er}, 3'b100);
        check_eq("lw_beat", {beats.size() == 1, beats[0].addr, beats[0].we, beats[0].strb},
                 {1'b1, 32'h100, 1'b0, 4'h0});

        err_next = 1;
        do_access(0, 32'h104, 0, 2'd0, rd, er, rr, wr, lat, nreq);
        err_next = 0;
        check_eq("buserr_flags", {rr, wr, er}, 3'b101);
        check_eq("buserr_data", rd, 0);

        do_access(1, 32'h203, 32'h1234_56AB, 2'd1, rd, er, rr, wr, lat, nreq);
        model_write(32'h203, 32'h1234_56AB, 1);
        check_eq("sb_lat", lat, 3);
        check_eq("sb_rdy", {rr, wr, er}, 3'b010);
        check_eq("sb_beat", {beats.size() == 1, beats[0].addr, beats[0].we, beats[0].strb, beats[0].wdata},
                 {1'b1, 32'h200, 1'b1, 4'b1000, 32'hAB00_0000});

        rd_force.push_back(32'h1122_3344); rd_force.push_back(32'h5566_7788);
        do_access(0, 32'h3FF, 0, 2'd2, rd, er, rr, wr, lat, nreq);
        check_eq("lh_lat", lat, 5);
        check_eq("lh_data", rd, 32'h0000_8811);
        check_eq("lh_beats", beats.size(), 2);
        if (beats.size() == 2) check_eq("lh_addrs", {beats[0].addr, beats[1].addr}, {32'h3FC, 32'h400});

        do_access(1, 32'hFFFF_FFFE, 32'hAABB_CCDD, 2'd0, rd, er, rr, wr, lat, nreq);
        model_write(32'hFFFF_FFFE, 32'hAABB_CCDD, 4);
        check_eq("sw_lat", lat, 5);
        check_eq("sw_beats", beats.size(), 2);
        if (beats.size() == 2) begin
            check_eq("sw_b0", {beats[0].addr, beats[0].strb, beats[0].wdata}, {32'hFFFF_FFFC, 4'b1100, 32'hCCDD_0000});
            check_eq("sw_b1", {beats[1].addr, beats[1].strb, beats[1].wdata}, {32'h0, 4'b0011, 32'h0000_AABB});
        end

        do_access(0, 32'h1000, 0, 2'd0, rd, er, rr, wr, lat, nreq);
        check_eq("pre_ill_data", rd, model_read(32'h1000, 4));
        do_access(0, 32'h40, 0, 2'd3, rd, er, rr, wr, lat, nreq);
        check_eq("ill_lat", lat, 1);
        check_eq("ill_flags", {rr, wr, er}, 3'b101);
        check_eq("ill_noreq", nreq, 0);
        check_eq("ill_data", rd, 0);

        gnt_block = 1;
        do_access(0, 32'h500, 0, 2'd0, rd, er, rr, wr, lat, nreq);
        gnt_block = 0;
        check_eq("to_lat", lat, 9);
        check_eq("to_nreq", nreq, 8);
        check_eq("to_flags", {rr, wr, er}, 3'b101);
        @(posedge clk); #1 inject_rv = 1;
        @(posedge clk); #1 inject_rv = 0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_read_ready || mem_write_ready || bus_req) cnt++;
        end
        check_eq("late_rvalid_ignored", cnt, 0);
        check_eq("late_rvalid_data", mem_data_in, 0);

        do_access(0, 32'h1004, 0, 2'd0, rd, er, rr, wr, lat, nreq);
        check_eq("pre_rst_data", rd, model_read(32'h1004, 4));
        rv_wait = 6; beats.delete();
        @(posedge clk); #1;
        mem_addr = 32'h8002; mem_data = 32'h0102_0304; byte_size = 2'd0; mem_write_en = 1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_req0", bus_req, 1);
        @(negedge clk);
        rst = 1; #1;
        check_eq("rst_bus", {bus_req, bus_we, bus_wstrb, bus_addr}, 0);
        check_eq("rst_wdata", bus_wdata, 0);
        check_eq("rst_mem", {mem_read_ready, mem_write_ready, mem_err, mem_data_in}, 0);
        mem_write_en = 0;
        @(negedge clk); rst = 0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_read_ready || mem_write_ready || mem_err) cnt++;
        end
        check_eq("rst_stale_ignored", cnt, 0);
        rv_wait = 0;
        do_access(0, 32'h100, 0, 2'd0, rd, er, rr, wr, lat, nreq);
        check_eq("post_rst_lat", lat, 3);
        check_eq("post_rst_data", rd, model_read(32'h100, 4));

        for (int t = 0; t < 150; t++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            a = 32'h1000 + 32'($urandom_range(0, 63));
            d = $urandom;
            gnt_wait = $urandom_range(0, 3);
            rv_wait = $urandom_range(0, 3);
            n = size_bytes(sz);
            exp = model_read(a, n);
            expb = (int'(a[1:0]) + n > 4) ? 2 : 1;
            do_access(we, a, d, sz, rd, er, rr, wr, lat, nreq);
            if (we) model_write(a, d, n);
            check_eq("rnd_flags", {rr, wr, er}, we ? 3'b010 : 3'b100);
            if (!we) check_eq("rnd_rdata", rd, exp);
            check_eq("rnd_beats", beats.size(), expb);
            check_eq("rnd_b0addr", beats[0].addr, {a[31:2], 2'b00});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Load/store bus adapter that sits directly downstream of the core's memory-access execute stage. It takes that stage's level-held read/write requests (address, data, byte_size) and turns them into word-aligned single-outstanding bus transactions with byte strobes. Misaligned halfword and word accesses are split into two bus beats. It returns right-aligned read data and one-cycle ready pulses.

## Interface
- TIMEOUT_CYC, 255: cycles to wait for bus_gnt or bus_rvalid before aborting with an error; 8-bit counter.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_read_en  in  1  read request; held high until mem_read_ready is sampled
- mem_write_en  in  1  write request; held high until mem_write_ready is sampled
- mem_addr  in  32  byte address
- mem_data  in  32  write data, right-aligned
- byte_size  in  2  access size: 0 = word, 1 = byte, 2 = half, 3 = illegal
- mem_data_in  out  32  read data, right-aligned, upper bits zero
- mem_read_ready  out  1  one-cycle pulse: read complete
- mem_write_ready  out  1  one-cycle pulse: write complete
- mem_err  out  1  one-cycle pulse, coincident with the ready pulse: access failed
- bus_req  out  1  bus request valid
- bus_we  out  1  1 = write beat
- bus_addr  out  32  word-aligned beat address; bits [1:0] always 0
- bus_wdata  out  32  lane-positioned write data
- bus_wstrb  out  4  byte-lane enables; 0 on reads
- bus_gnt  in  1  request accepted in the current cycle when bus_req = 1
- bus_rvalid  in  1  beat response (read data or write ack)
- bus_rdata  in  32  read data, valid with bus_rvalid
- bus_err  in  1  beat error, valid with bus_rvalid

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - Sample enables each posedge.
  - mem_read_en & mem_write_en both high, or byte_size = 3: go to RESP with the error flag set; no bus access.
  - Otherwise latch addr, data, size and we, then go to REQ0.
- Beat arithmetic (size n = 1/2/4 bytes, offset o = addr[1:0]):
  - mask8 = ((1<<n)-1) << o.
  - wdata64 = mem_data << (8*o).
  - Beat0: address addr & ~3, wstrb mask8[3:0], wdata wdata64[31:0].
  - Beat1 is needed iff mask8[7:4] != 0. Beat1: address (addr & ~3) + 4, wrapping 0xFFFFFFFC -> 0x00000000; wstrb mask8[7:4]; wdata wdata64[63:32].
- REQ0/REQ1:
  - bus_req = 1; addr, we, wdata and wstrb held stable.
  - On bus_gnt, go to WAIT0/WAIT1.
- WAIT0/WAIT1:
  - On bus_rvalid, capture bus_rdata into the low/high half of a 64-bit buffer and OR bus_err into the error flag.
  - WAIT0 goes to REQ1 if beat1 is needed and no error; otherwise to RESP.
- RESP (one cycle):
  - Pulse mem_read_ready or mem_write_ready per the latched we, and mem_err = error flag.
  - mem_data_in = (buf64 >> 8*o) masked to n bytes; holds its value until the next read completes; 0 on error.
  - Next state is IDLE, unconditionally. Enables are ignored during RESP.
- Timeout:
  - The counter clears on entry to each REQ/WAIT state and increments each cycle spent there.
  - On reaching TIMEOUT_CYC: drop bus_req, set the error flag, go to RESP.
- A bus_rvalid arriving outside WAIT states is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0; buffer 0.
- Asynchronous rst mid-transaction:
  - bus_req and the ready pulses drop immediately.
  - Any later bus_rvalid for the aborted beat is ignored.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Zero-wait bus (gnt in the same cycle as req, rvalid the next cycle):
  - Enable first sampled at edge E0.
  - Aligned access: REQ0 in cycle 1, WAIT0 in cycle 2, ready in cycle 3.
  - Split access: ready in cycle 5.
- Illegal access: ready plus mem_err in cycle 1.
- Ready is high for exactly one cycle.
- The upstream stage drops its enable at the edge ending the RESP cycle, so IDLE never re-accepts the same request.

## Test plan
- Aligned lw at 0x100, bus returns 0xDEADBEEF with zero wait -> bus_addr 0x100, bus_wstrb 0; mem_read_ready in cycle 3; mem_data_in = 0xDEADBEEF.
- sb at 0x203, data 0x123456AB -> one beat: bus_addr 0x200, bus_wstrb 4'b1000, bus_wdata 0xAB000000; mem_write_ready in cycle 3.
- Misaligned lh at 0x3FF; beat0 rdata 0x11223344, beat1 rdata 0x55667788 -> beats at 0x3FC and 0x400; mem_data_in = 0x00008811; ready in cycle 5.
- Misaligned sw at 0xFFFFFFFE, data 0xAABBCCDD -> beat0 at 0xFFFFFFFC with wstrb 1100 and wdata 0xCCDD0000; beat1 at 0x00000000 with wstrb 0011 and wdata 0x0000AABB.
- bus_gnt held low with TIMEOUT_CYC = 8 -> bus_req drops after 8 cycles; ready and mem_err pulse once; a late bus_rvalid is ignored. Separately, byte_size = 3 -> immediate mem_err with no bus_req.
- Assert rst during WAIT0 of a split write -> all outputs 0 at once; after release, a new lw completes normally.
